uart_rx_8bit: RTL and testbench
===============================

Name: uart_rx_8bit

Overview:
- Receives 8N1 asynchronous serial frames on `rx`, LSB first, idle-high line.
- Presents each good byte on a parallel output with a single-cycle `valid` strobe.
- Is the receive counterpart of `uart_tx_8bit`: same framing, same baud parameters, so TX→RX loopback works directly.
- Sits between the board RX pin and the byte consumer (command parser / FIFO).

Parameters:
- CLK_FREQ, 20_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bits per second.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (integer divide), clock cycles per bit. Derived localparam; must be ≥ 4.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- data_out  output  8  last good received byte.
- valid  output  1  one-cycle pulse; `data_out` is new this cycle.
- busy  output  1  high from start-bit detection until the frame ends.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.

Behaviour:
- Input conditioning: `rx` passes through a 2-flop synchronizer, reset value 1.
  - Start detection uses the synchronized value plus one extra delay flop for falling-edge detection.
  - Total input latency is 2 cycles.
- Reset values: `data_out`=8'h00, `valid`=0, `busy`=0, `frame_err`=0. The FSM goes to IDLE, counters clear, synchronizer flops are set to 1.
- A reset mid-frame abandons the frame with no strobe. The receiver rearms only on a new falling edge.
- FSM states: IDLE, START, DATA, [PARITY], STOP, WAIT_IDLE.
- IDLE: on a synchronized falling edge, clear the bit-timer and go to START; `busy`=1.
- START: count to CLKS_PER_BIT/2 − 1 (mid start bit).
  - If the line is low, clear the timer and go to DATA.
  - If the line is high, treat it as a glitch: return to IDLE with no outputs and `busy`=0.
- DATA: every CLKS_PER_BIT cycles, sample the line into a shift register, LSB first. The bit index counts 0..7; after bit 7, go to STOP (or PARITY).
- STOP: sample once at mid stop bit.
  - Line = 1: `data_out` takes the shift register, `valid` pulses 1 cycle, go to IDLE, `busy`=0 in the same cycle. No wait for the end of the stop bit, so back-to-back frames with zero idle time are received.
  - Line = 0: `frame_err` pulses, `data_out` keeps its old value, no `valid`, go to WAIT_IDLE.
- WAIT_IDLE: stay (`busy`=1) until the synchronized line is high, then go to IDLE. A break condition therefore yields exactly one `frame_err`.
- `valid` and `frame_err` are never high together. Each is high for exactly one cycle per frame.
- Timing: the bit timer is $clog2(CLKS_PER_BIT) wide and wraps to 0 at CLKS_PER_BIT−1. Sampling points are at ½, 1½, … 9½ bit periods after the detected edge.
- Latency: from the `rx` falling edge to `valid` is 2 + 9·CLKS_PER_BIT + CLKS_PER_BIT/2 cycles, ±1.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1; the PARITY state samples bit 9 at its midpoint and compares it with the XOR of the data bits.
  - Adds output port `parity_err` (1 bit, reset 0).
  - On mismatch with a good stop bit: `parity_err` pulses, no `valid`, `data_out` unchanged.
  - A stop failure reports `frame_err` only.
- Undefined: no PARITY state, no `parity_err` port; frame is 8N1.

Decomposition:
- Package `uart_pkg`: state enum typedef; parity-type constant; function `clks_per_bit(clk_freq, baud)`. Shared with `uart_tx_8bit`.
- Sub-module `uart_rx_sync`: 2-flop synchronizer plus falling-edge detector.
  - Outputs `rx_s` and `fall`, reset to idle-high.
  - Reusable for other asynchronous inputs.
- FSM, bit timer and shift register stay in `uart_rx_8bit`.

Test Plan:
- Bench settings: CLK_FREQ=20_000_000, BAUD_RATE=1_000_000, so CLKS_PER_BIT=20 and `clk` period is 50 ns.
- Loopback: drive `uart_tx_8bit` with 8'h9A → `data_out`=8'h9A, `valid` pulses once at edge+192±1 cycles, `frame_err`=0.
- Back-to-back: frames 8'h00, 8'hFF, 8'h55 with zero idle time → three `valid` pulses in order, no errors.
- Glitch: `rx` low for 5 cycles, then high → no `valid`, `busy` drops within 12 cycles; a following frame 8'hA5 is received correctly.
- Framing error: frame 8'h3C with stop bit 0, then line held low for 40 cycles → exactly one `frame_err`, no `valid`, `data_out` holds its previous value; the next good frame 8'h81 is received.
- Reset mid-frame: assert `rst` for 1 cycle during data bit 4 of 8'hC3 → all outputs 0 immediately, no strobe for that frame; the next frame 8'h12 is received.
- With UART_RX_PARITY_EN defined: 8'h9A (even parity bit 0) → `valid`; the same frame with parity bit 1 → `parity_err` pulse, no `valid`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity sense and baud divider.
// Used by both uart_rx_8bit and uart_tx_8bit.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } uart_state_t;

  // 0 = even parity, 1 = odd parity
  localparam logic PARITY_ODD = 1'b0;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer with a falling-edge detector for an async input.
// Idle-high reset; no edge is reported until the line has been seen high.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rx_s,
  output logic fall
);

  logic s1, s2, s3;
  logic live1, live2;
  logic hi_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      s3      <= 1'b1;
      live1   <= 1'b0;
      live2   <= 1'b0;
      hi_seen <= 1'b0;
    end else begin
      s1      <= sig;
      s2      <= s1;
      s3      <= s2;
      live1   <= 1'b1;
      live2   <= live1;
      // s2 only carries real line data once live2 is set
      hi_seen <= hi_seen | (live2 & s2);
    end
  end

  assign rx_s = s2;
  assign fall = hi_seen & s3 & ~s2;

endmodule

// File: rtl/uart_rx_8bit.sv
// 8N1 UART receiver with mid-bit sampling and one-cycle valid strobe.
// Define UART_RX_PARITY_EN for 8E1 framing and a parity_err output.
module uart_rx_8bit
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 20_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       busy,
  output logic       frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);

  uart_state_t   state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    data_n;
  logic          valid_n, ferr_n;
  logic          rx_s, fall, tick;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_n, perr_n;
`endif

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .sig  (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  assign tick = (timer == T_FULL);
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      idx       <= '0;
      shreg     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      data_out  <= data_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_q      <= par_n;
      parity_err <= perr_n;
    end
  end
`endif

  always_comb begin
    state_n = state;
    timer_n = timer + 1'b1;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = data_out;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n   = par_q;
    perr_n  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        timer_n = '0;
        if (fall) state_n = START;
      end
      START: begin
        // mid start bit: a high line means the edge was a glitch
        if (timer == T_HALF) begin
          timer_n = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick) begin
          timer_n = '0;
          shreg_n = {rx_s, shreg[7:1]};
          idx_n   = idx + 1'b1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          timer_n = '0;
          par_n   = rx_s;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          timer_n = '0;
          if (rx_s) begin
            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_q != ((^shreg) ^ PARITY_ODD)) begin
              perr_n = 1'b1;
            end else begin
              valid_n = 1'b1;
              data_n  = shreg;
            end
`else
            valid_n = 1'b1;
            data_n  = shreg;
`endif
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        timer_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        timer_n = '0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_8bit.sv
// Self-checking bench for uart_rx_8bit: frame table plus scoreboard queue.
// Build with UART_RX_PARITY_EN to exercise 8E1 framing.
module tb_uart_rx_8bit;

  localparam int CPB = 20;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  localparam int LAT = 2 + NB * CPB + CPB / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       valid, busy, frame_err, perr;

  always #25 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_8bit #(
    .CLK_FREQ  (20_000_000),
    .BAUD_RATE (1_000_000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .busy      (busy),
    .frame_err (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(perr)
`endif
  );

`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  // kind: 0 = valid, 1 = frame_err, 2 = parity_err
  typedef struct {
    int         kind;
    logic [7:0] data;
    longint     t0;
  } ev_t;

  typedef struct {
    logic [7:0] d;
    bit         stop;
    bit         pflip;
    bit         glitch;
    int         low_after;
    int         idle_after;
    int         kind;
  } vec_t;

  ev_t        sbq[$];
  vec_t       vt[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_last = 8'h00;

  function automatic vec_t mk(input logic [7:0] d, input bit stop,
                              input bit pflip, input bit glitch,
                              input int low_after, input int idle_after,
                              input int kind);
    vec_t v;
    v.d = d; v.stop = stop; v.pflip = pflip; v.glitch = glitch;
    v.low_after = low_after; v.idle_after = idle_after; v.kind = kind;
    return v;
  endfunction

  task automatic chk(input string name, input longint act,
                     input longint lo, input longint hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] d);
    ev_t e;
    if (kind == 0) exp_last = d;
    e.kind = kind;
    e.data = exp_last;
    e.t0   = cyc;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    int  act;
    ev_t e;
    act = -1;
    case ({valid, frame_err, perr})
      3'b000:  act = -1;
      3'b100:  act = 0;
      3'b010:  act = 1;
      3'b001:  act = 2;
      default: act = 3;
    endcase
    if (act >= 0) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_strobe: got kind %0d, want none", act);
      end else begin
        e = sbq.pop_front();
        chk("strobe_kind", act, e.kind, e.kind);
        chk("data_out", data_out, e.data, e.data);
        chk("latency", cyc - e.t0, LAT - 1, LAT + 1);
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_in_bit(input logic b);
    rx = b;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_data", data_out, 0, 0);
    chk("midrst_valid", valid, 0, 0);
    chk("midrst_busy", busy, 0, 0);
    chk("midrst_ferr", frame_err, 0, 0);
    chk("midrst_perr", perr, 0, 0);
    rst = 1'b0;
    repeat (11) @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v, input int rst_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == rst_bit) reset_in_bit(v.d[i]);
      else drive_bit(v.d[i]);
    end
`ifdef UART_RX_PARITY_EN
    drive_bit((^v.d) ^ v.pflip);
`endif
    drive_bit(v.stop);
  endtask

  task automatic glitch_seq();
    bit dropped;
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    @(negedge clk);
    chk("glitch_busy_hi", busy, 1, 1);
    dropped = 1'b0;
    for (int k = 0; k < 12 && !dropped; k++) begin
      @(negedge clk);
      if (!busy) dropped = 1'b1;
    end
    chk("glitch_busy_drop", dropped, 1, 1);
    @(posedge clk);
    #1;
    idle(20);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    chk("drain", sbq.size(), 0, 0);
    if (sbq.size() != 0) sbq.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt.push_back(mk(8'h9A, 1, 0, 0, 0, 40, 0));
    vt.push_back(mk(8'h00, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(8'hFF, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(8'h55, 1, 0, 0, 0, 40, 0));
    vt.push_back(mk(8'hA5, 1, 0, 1, 0, 40, 0));
    vt.push_back(mk(8'h3C, 0, 0, 0, 40, 40, 1));
    vt.push_back(mk(8'h81, 1, 0, 0, 0, 40, 0));
`ifdef UART_RX_PARITY_EN
    vt.push_back(mk(8'h9A, 1, 0, 0, 0, 40, 0));
    vt.push_back(mk(8'h9A, 1, 1, 0, 0, 40, 2));
    vt.push_back(mk(8'h66, 1, 0, 0, 0, 40, 0));
`endif

    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_data", data_out, 0, 0);
    chk("rst_valid", valid, 0, 0);
    chk("rst_busy", busy, 0, 0);
    chk("rst_ferr", frame_err, 0, 0);
    chk("rst_perr", perr, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(10);
    chk("idle_busy", busy, 0, 0);

    foreach (vt[i]) begin
      if (vt[i].glitch) glitch_seq();
      push(vt[i].kind, vt[i].d);
      send(vt[i], -1);
      if (vt[i].low_after > 0) begin
        rx = 1'b0;
        repeat (vt[i].low_after) @(posedge clk);
        #1;
      end
      idle(vt[i].idle_after);
    end
    wait_drain();

    send(mk(8'hC3, 1, 0, 0, 0, 0, 0), 4);
    exp_last = 8'h00;
    idle(40);
    push(0, 8'h12);
    send(mk(8'h12, 1, 0, 0, 0, 0, 0), -1);
    idle(40);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

endmodule
